writeback_arbiter: RTL and testbench



---
 rtl/writeback_arbiter_pkg.sv | 59 +++++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/writeback_arbiter.sv | 118 +++++++++++
 tb/tb_writeback_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types: register/exception encodings, the per-source request
// record, source indices and the idle payload of the writeback port.
package writeback_arbiter_pkg;

    localparam int DataWidth = 32;
    localparam int RobDepth  = 32;
    localparam int RobIdW    = $clog2(RobDepth);
    localparam int WbSrcNum  = 4;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MDU = 1;
    localparam int WB_SRC_LSU = 2;
    localparam int WB_SRC_BR  = 3;

    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'd0,
        TYPE_GPR  = 2'd1,
        TYPE_FPR  = 2'd2,
        TYPE_ROB  = 2'd3
    } RegType_t;

    typedef struct packed {
        RegType_t            regtype;
        logic [RobIdW-1:0]   addr;
    } RegFile_t;

    typedef enum logic [3:0] {
        EXP_I_MISS_ALIGN = 4'd0,
        EXP_I_FAULT      = 4'd1,
        EXP_ILLEGAL_INST = 4'd2,
        EXP_BREAK        = 4'd3,
        EXP_D_MISS_ALIGN = 4'd4,
        EXP_D_FAULT      = 4'd5,
        EXP_ECALL        = 4'd8
    } ExpCode_t;

    typedef struct packed {
        RegFile_t               rd;
        logic [DataWidth-1:0]   data;
        logic                   exp_;
        ExpCode_t               exp_code;
        logic                   pred_miss_;
        logic                   jump_miss_;
    } WbReq_t;

    // Payload the writeback port shows whenever no result is being delivered.
    localparam WbReq_t WbReqReset = '{
        rd:         '0,
        data:       '0,
        exp_:       Disable_,
        exp_code:   EXP_I_MISS_ALIGN,
        pred_miss_: Disable_,
        jump_miss_: Disable_
    };

endpackage

// File: rtl/wb_fifo.sv
// Two-entry result buffer for one writeback source; a push while full is lost,
// and clear empties it without touching the stored words.
module wb_fifo
    import writeback_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   push_,
    input  WbReq_t din,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output WbReq_t head
);

    WbReq_t     mem_q [2];
    WbReq_t     mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_push  = (push_ == Enable_) && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

    property p_no_push_when_full;
        @(posedge clk) disable iff (reset || clear) !((push_ == Enable_) && full);
    endproperty
    assert property (p_no_push_when_full);

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin merge of per-source writeback buffers into the single registered
// reorder-buffer writeback port; a ROB flush drops everything still buffered.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA    = DataWidth,
    parameter int NUM_SRC = WbSrcNum,
    parameter int SRC     = $clog2(NUM_SRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_,
    input  logic            src_e_        [NUM_SRC],
    input  RegFile_t        src_rd        [NUM_SRC],
    input  logic [DATA-1:0] src_data      [NUM_SRC],
    input  logic            src_exp_      [NUM_SRC],
    input  ExpCode_t        src_exp_code  [NUM_SRC],
    input  logic            src_pred_miss_[NUM_SRC],
    input  logic            src_jump_miss_[NUM_SRC],
    output logic            src_busy      [NUM_SRC],
    output logic            wb_e_,
    output RegFile_t        wb_rd,
    output logic [DATA-1:0] wb_data,
    output logic            wb_exp_,
    output ExpCode_t        wb_exp_code,
    output logic            wb_pred_miss_,
    output logic            wb_jump_miss_
);

    WbReq_t         fifo_din   [NUM_SRC];
    WbReq_t         fifo_head  [NUM_SRC];
    logic           fifo_full  [NUM_SRC];
    logic           fifo_empty [NUM_SRC];
    logic           fifo_pop   [NUM_SRC];
    logic           flush_now;

    logic           grant_vld;
    logic [SRC-1:0] grant_idx;
    logic [SRC-1:0] cand;
    logic [SRC-1:0] last_grant_q, last_grant_d;
    logic           wb_e_q, wb_e_d;
    WbReq_t         wb_q, wb_d;

    assign flush_now = (flush_ == Enable_);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign fifo_din[i] = '{
            rd:         src_rd[i],
            data:       DataWidth'(src_data[i]),
            exp_:       src_exp_[i],
            exp_code:   src_exp_code[i],
            pred_miss_: src_pred_miss_[i],
            jump_miss_: src_jump_miss_[i]
        };

        wb_fifo u_fifo (
            .clk   (clk),
            .reset (reset),
            .clear (flush_now),
            .push_ (src_e_[i]),
            .din   (fifo_din[i]),
            .pop   (fifo_pop[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .head  (fifo_head[i])
        );

        assign src_busy[i] = fifo_full[i];
    end

    // Search starts just past the previous winner so every source is reached
    // within NUM_SRC grants; entries pushed this cycle are not yet visible.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        cand      = last_grant_q;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC'((int'(last_grant_q) + k) % NUM_SRC);
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            fifo_pop[i] = grant_vld && (grant_idx == SRC'(i));
        end

        wb_e_d       = Disable_;
        wb_d         = WbReqReset;
        last_grant_d = last_grant_q;
        if (!flush_now && grant_vld) begin
            wb_e_d       = Enable_;
            wb_d         = fifo_head[grant_idx];
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_e_q       <= Disable_;
            wb_q         <= WbReqReset;
            last_grant_q <= SRC'(NUM_SRC - 1);
        end else begin
            wb_e_q       <= wb_e_d;
            wb_q         <= wb_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wb_e_         = wb_e_q;
    assign wb_rd         = wb_q.rd;
    assign wb_data       = DATA'(wb_q.data);
    assign wb_exp_       = wb_q.exp_;
    assign wb_exp_code   = wb_q.exp_code;
    assign wb_pred_miss_ = wb_q.pred_miss_;
    assign wb_jump_miss_ = wb_q.jump_miss_;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: queue-based reference model checked every
// cycle, plus hand-derived expectations for latency, ordering, busy and flush.
`timescale 1ns/1ps
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N = WbSrcNum;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 flush_ = 1'b1;
    logic                 src_e_        [N];
    RegFile_t             src_rd        [N];
    logic [DataWidth-1:0] src_data      [N];
    logic                 src_exp_      [N];
    ExpCode_t             src_exp_code  [N];
    logic                 src_pred_miss_[N];
    logic                 src_jump_miss_[N];
    logic                 src_busy      [N];
    logic                 wb_e_;
    RegFile_t             wb_rd;
    logic [DataWidth-1:0] wb_data;
    logic                 wb_exp_;
    ExpCode_t             wb_exp_code;
    logic                 wb_pred_miss_;
    logic                 wb_jump_miss_;

    int checks   = 0;
    int failures = 0;

    writeback_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .flush_         (flush_),
        .src_e_         (src_e_),
        .src_rd         (src_rd),
        .src_data       (src_data),
        .src_exp_       (src_exp_),
        .src_exp_code   (src_exp_code),
        .src_pred_miss_ (src_pred_miss_),
        .src_jump_miss_ (src_jump_miss_),
        .src_busy       (src_busy),
        .wb_e_          (wb_e_),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_exp_        (wb_exp_),
        .wb_exp_code    (wb_exp_code),
        .wb_pred_miss_  (wb_pred_miss_),
        .wb_jump_miss_  (wb_jump_miss_)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per source, round-robin pointer as an integer.
    WbReq_t mq [N][$];
    int     m_lg      = N - 1;
    bit     m_started = 1'b0;
    logic   m_e       = Disable_;
    WbReq_t m_req     = WbReqReset;

    function automatic WbReq_t src_req(input int i);
        return '{rd: src_rd[i], data: src_data[i], exp_: src_exp_[i],
                 exp_code: src_exp_code[i], pred_miss_: src_pred_miss_[i],
                 jump_miss_: src_jump_miss_[i]};
    endfunction

    always @(posedge clk) begin
        int sz [N];
        int g;
        m_started = 1'b1;
        if (reset || flush_ == Enable_) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            if (reset) m_lg = N - 1;
            m_e   = Disable_;
            m_req = WbReqReset;
        end else begin
            for (int i = 0; i < N; i++) sz[i] = mq[i].size();
            g = -1;
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && sz[(m_lg + k) % N] > 0) g = (m_lg + k) % N;
            end
            if (g >= 0) begin
                m_req = mq[g].pop_front();
                m_e   = Enable_;
                m_lg  = g;
            end else begin
                m_e   = Disable_;
                m_req = WbReqReset;
            end
            for (int i = 0; i < N; i++) begin
                if (src_e_[i] == Enable_ && sz[i] < 2) mq[i].push_back(src_req(i));
            end
        end
    end

    logic [DataWidth-1:0] wb_log [$];

    always @(negedge clk) begin
        if (m_started) begin
            check("wb_e_", wb_e_, m_e);
            if (m_e == Enable_) begin
                check("wb_rd", wb_rd, m_req.rd);
                check("wb_data", wb_data, m_req.data);
                check("wb_exp_", wb_exp_, m_req.exp_);
                check("wb_exp_code", wb_exp_code, m_req.exp_code);
                check("wb_pred_miss_", wb_pred_miss_, m_req.pred_miss_);
                check("wb_jump_miss_", wb_jump_miss_, m_req.jump_miss_);
            end
            for (int i = 0; i < N; i++)
                check($sformatf("src_busy[%0d]", i), src_busy[i], mq[i].size() == 2);
            if (wb_e_ == Enable_) wb_log.push_back(wb_data);
        end
    end

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            src_e_[i]         = Disable_;
            src_rd[i]         = '0;
            src_data[i]       = '0;
            src_exp_[i]       = Disable_;
            src_exp_code[i]   = EXP_I_MISS_ALIGN;
            src_pred_miss_[i] = Disable_;
            src_jump_miss_[i] = Disable_;
        end
    endtask

    task automatic set_push(input int i, input logic [31:0] data, input int addr);
        src_e_[i]         = Enable_;
        src_rd[i]         = '{regtype: TYPE_GPR, addr: RobIdW'(addr)};
        src_data[i]       = data;
        src_exp_[i]       = Disable_;
        src_exp_code[i]   = EXP_I_MISS_ALIGN;
        src_pred_miss_[i] = Disable_;
        src_jump_miss_[i] = Disable_;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        flush_ = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int nxt;
        int s0 [$];
        idle_all();

        // Single ALU result: reset state, then 2-cycle latency, one cycle wide
        do_reset();
        check("rst_wb_e_", wb_e_, Disable_);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_exp_code", wb_exp_code, EXP_I_MISS_ALIGN);
        check("rst_busy0", src_busy[0], 1'b0);
        set_push(WB_SRC_ALU, 32'haaaa, 3);
        @(negedge clk); idle_all();
        check("t1_edge1_wb_e_", wb_e_, Disable_);
        @(negedge clk);
        check("t1_edge2_wb_e_", wb_e_, Enable_);
        check("t1_edge2_data", wb_data, 32'haaaa);
        check("t1_edge2_rd", wb_rd, {TYPE_GPR, 5'd3});
        @(negedge clk);
        check("t1_edge3_wb_e_", wb_e_, Disable_);

        // All four sources at once
        do_reset();
        wb_log.delete();
        for (int i = 0; i < N; i++) set_push(i, 32'h10 + i, i);
        @(negedge clk); idle_all();
        repeat (6) @(negedge clk);
        check("t2_count", wb_log.size(), 4);
        for (int k = 0; k < 4 && k < wb_log.size(); k++)
            check($sformatf("t2_seq%0d", k), wb_log[k], 32'h10 + k);

        // Sources 0 and 2 pushing whenever not busy
        do_reset();
        wb_log.delete();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i += 2) begin
                if (mq[i].size() < 2) set_push(i, (i << 8) | c, c);
                else src_e_[i] = Disable_;
            end
            @(negedge clk);
        end
        idle_all();
        repeat (10) @(negedge clk);
        check("t3_enough", wb_log.size() >= 8, 1'b1);
        for (int k = 0; k < 8 && k < wb_log.size(); k++)
            check($sformatf("t3_src%0d", k), wb_log[k][11:8], (k % 2 == 0) ? 0 : 2);

        // Back-pressure on source 0 while 1..3 stream; last grant left at 0
        do_reset();
        set_push(WB_SRC_ALU, 32'h0ff, 1);
        @(negedge clk); idle_all();
        repeat (3) @(negedge clk);
        wb_log.delete();
        nxt = 0;
        for (int c = 0; c < 14; c++) begin
            if (c >= 2 && c <= 4) check($sformatf("t4_busy_c%0d", c), src_busy[0], 1'b1);
            if (c == 5) check("t4_busy_drop", src_busy[0], 1'b0);
            for (int i = 1; i < N; i++) begin
                if (mq[i].size() < 2) set_push(i, (i << 8) | c, c);
                else src_e_[i] = Disable_;
            end
            if (nxt < 3 && mq[0].size() < 2) begin
                set_push(0, nxt + 1, nxt);
                nxt++;
            end else begin
                src_e_[0] = Disable_;
            end
            @(negedge clk);
        end
        idle_all();
        repeat (16) @(negedge clk);
        foreach (wb_log[k]) if (wb_log[k][11:8] == 4'd0) s0.push_back(int'(wb_log[k]));
        check("t4_s0_count", s0.size(), 3);
        for (int k = 0; k < 3 && k < s0.size(); k++)
            check($sformatf("t4_s0_order%0d", k), s0[k], k + 1);

        // Flag passthrough, granted in order ALU, LSU, BR
        do_reset();
        set_push(WB_SRC_ALU, 32'h500, 0);
        src_jump_miss_[WB_SRC_ALU] = Enable_;
        set_push(WB_SRC_LSU, 32'h502, 2);
        src_exp_[WB_SRC_LSU] = Enable_;
        src_exp_code[WB_SRC_LSU] = EXP_I_MISS_ALIGN;
        set_push(WB_SRC_BR, 32'h503, 3);
        src_pred_miss_[WB_SRC_BR] = Enable_;
        src_exp_code[WB_SRC_BR] = EXP_ILLEGAL_INST;
        @(negedge clk); idle_all();
        @(negedge clk);
        check("t5_alu_jump", wb_jump_miss_, Enable_);
        check("t5_alu_exp", wb_exp_, Disable_);
        @(negedge clk);
        check("t5_lsu_exp", wb_exp_, Enable_);
        check("t5_lsu_code", wb_exp_code, EXP_I_MISS_ALIGN);
        check("t5_lsu_pred", wb_pred_miss_, Disable_);
        @(negedge clk);
        check("t5_br_pred", wb_pred_miss_, Enable_);
        check("t5_br_code", wb_exp_code, EXP_ILLEGAL_INST);
        check("t5_br_exp", wb_exp_, Disable_);

        // Flush with five entries buffered and a concurrent ALU push
        do_reset();
        for (int i = 0; i < N; i++) set_push(i, 32'h600 + i, i);
        @(negedge clk); idle_all();
        set_push(1, 32'h611, 1);
        set_push(2, 32'h612, 2);
        @(negedge clk); idle_all();
        check("t6_pre_busy1", src_busy[1], 1'b1);
        flush_ = Enable_;
        set_push(WB_SRC_ALU, 32'h6dd, 0);
        @(negedge clk); idle_all();
        wb_log.delete();
        flush_ = Disable_;
        check("t6_flush_wb_e_", wb_e_, Disable_);
        for (int i = 0; i < N; i++) check($sformatf("t6_busy%0d", i), src_busy[i], 1'b0);
        set_push(WB_SRC_ALU, 32'h6ee, 4);
        @(negedge clk); idle_all();
        check("t6_post1_wb_e_", wb_e_, Disable_);
        @(negedge clk);
        check("t6_post2_wb_e_", wb_e_, Enable_);
        check("t6_post2_data", wb_data, 32'h6ee);
        repeat (6) @(negedge clk);
        check("t6_log_count", wb_log.size(), 1);

        // Reset mid-operation drops buffers and returns priority to source 0
        do_reset();
        for (int i = 0; i < N; i++) set_push(i, 32'h700 + i, i);
        @(negedge clk); idle_all();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wb_log.delete();
        set_push(WB_SRC_BR, 32'h7a3, 3);
        set_push(WB_SRC_ALU, 32'h7a0, 0);
        @(negedge clk); idle_all();
        repeat (6) @(negedge clk);
        check("t7_count", wb_log.size(), 2);
        if (wb_log.size() == 2) begin
            check("t7_first", wb_log[0], 32'h7a0);
            check("t7_second", wb_log[1], 32'h7a3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
